// File: rtl/wb_grf_pkg.sv
// Shared constants for the MIPS write-back stage: widths, source-select and load-type codes.
package wb_grf_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned LINK_OFS = 8;
    localparam int unsigned SELW     = 3;

    // MemtoReg codes: write-back source select
    localparam logic [SELW-1:0] MTR_AO   = 3'd0;
    localparam logic [SELW-1:0] MTR_MD   = 3'd1;
    localparam logic [SELW-1:0] MTR_LINK = 3'd2;
    localparam logic [SELW-1:0] MTR_HILO = 3'd3;
    localparam logic [SELW-1:0] MTR_CP0  = 3'd4;

    // LdType codes: sub-word load extension
    localparam logic [SELW-1:0] LD_W  = 3'd0;
    localparam logic [SELW-1:0] LD_BU = 3'd1;
    localparam logic [SELW-1:0] LD_B  = 3'd2;
    localparam logic [SELW-1:0] LD_HU = 3'd3;
    localparam logic [SELW-1:0] LD_H  = 3'd4;

    // Return address written by jal/jalr; wraps at 32 bits.
    function automatic logic [DW-1:0] link_addr(input logic [DW-1:0] pc);
        return pc + DW'(LINK_OFS);
    endfunction

endpackage

// File: rtl/wb_grf_ld_ext.sv
// Load extender: picks the addressed byte/half from the aligned DM word (little-endian lanes)
// and zero- or sign-extends it according to the load type. Purely combinational.
module wb_grf_ld_ext
    import wb_grf_pkg::*;
(
    input  logic [DW-1:0]   md,
    input  logic [1:0]      ao_lo,
    input  logic [SELW-1:0] ld_type,
    output logic [DW-1:0]   ext_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: AOW[1:0]=0 addresses MDW[7:0]
    always_comb begin
        byte_sel = md[7:0];
        case (ao_lo)
            2'd0:    byte_sel = md[7:0];
            2'd1:    byte_sel = md[15:8];
            2'd2:    byte_sel = md[23:16];
            default: byte_sel = md[31:24];
        endcase
        half_sel = ao_lo[1] ? md[31:16] : md[15:0];
    end

    // Extension by load type; unknown codes behave as a full-word load
    always_comb begin
        ext_c = md;
        case (ld_type)
            LD_BU:   ext_c = {{(DW-8){1'b0}}, byte_sel};
            LD_B:    ext_c = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_HU:   ext_c = {{(DW-16){1'b0}}, half_sel};
            LD_H:    ext_c = {{(DW-16){half_sel[15]}}, half_sel};
            default: ext_c = md;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage with the 32x32 general register file.
// Selects the write-back datum, writes it on the rising edge, and serves two
// combinational read ports. Define GRF_BYPASS_EN to make a same-cycle write
// visible on the read ports (write-before-read); otherwise reads return the
// pre-edge array contents.
module wb_grf
    import wb_grf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [SELW-1:0] MemtoRegW,
    input  logic            RegWriteW,
    input  logic [SELW-1:0] LdTypeW,
    input  logic [DW-1:0]   MDW,
    input  logic [DW-1:0]   AOW,
    input  logic [AW-1:0]   WAW,
    input  logic [DW-1:0]   PCW,
    input  logic [DW-1:0]   HILO_resW,
    input  logic [DW-1:0]   CP0_DOutW,
    input  logic [AW-1:0]   RA1,
    input  logic [AW-1:0]   RA2,
    output logic [DW-1:0]   RD1,
    output logic [DW-1:0]   RD2,
    output logic [DW-1:0]   WDW,
    output logic            WEW
);

    // $0 has no storage; entries 1..NREG-1 only
    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];
    logic [DW-1:0] ext_md;

    wb_grf_ld_ext u_ld_ext (
        .md      (MDW),
        .ao_lo   (AOW[1:0]),
        .ld_type (LdTypeW),
        .ext_c   (ext_md)
    );

    // Write-back source select; undefined codes write zero
    always_comb begin
        WDW = '0;
        case (MemtoRegW)
            MTR_AO:   WDW = AOW;
            MTR_MD:   WDW = ext_md;
            MTR_LINK: WDW = link_addr(PCW);
            MTR_HILO: WDW = HILO_resW;
            MTR_CP0:  WDW = CP0_DOutW;
            default:  WDW = '0;
        endcase
    end

    // Effective write enable, exported for W-stage forwarding; not gated by reset
    assign WEW = RegWriteW && (WAW != '0);

    // Next array state: synchronous reset wins over a same-cycle write
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_d[i] = '0;
            end
        end else if (WEW) begin
            regs_d[WAW] = WDW;
        end
    end

    // Register array update
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read ports: $0 reads zero, optional write-before-read bypass
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (RA1 != '0) begin
`ifdef GRF_BYPASS_EN
            if (WEW && (RA1 == WAW)) RD1 = WDW;
            else                     RD1 = regs_q[RA1];
`else
            RD1 = regs_q[RA1];
`endif
        end
        if (RA2 != '0) begin
`ifdef GRF_BYPASS_EN
            if (WEW && (RA2 == WAW)) RD2 = WDW;
            else                     RD2 = regs_q[RA2];
`else
            RD2 = regs_q[RA2];
`endif
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: expected values are queued when stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MemtoRegW;
    logic        RegWriteW;
    logic [2:0]  LdTypeW;
    logic [31:0] MDW, AOW, PCW, HILO_resW, CP0_DOutW;
    logic [4:0]  WAW, RA1, RA2;
    logic [31:0] RD1, RD2, WDW;
    logic        WEW;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .MemtoRegW (MemtoRegW),
        .RegWriteW (RegWriteW),
        .LdTypeW   (LdTypeW),
        .MDW       (MDW),
        .AOW       (AOW),
        .WAW       (WAW),
        .PCW       (PCW),
        .HILO_resW (HILO_resW),
        .CP0_DOutW (CP0_DOutW),
        .RA1       (RA1),
        .RA2       (RA2),
        .RD1       (RD1),
        .RD2       (RD2),
        .WDW       (WDW),
        .WEW       (WEW)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; MemtoRegW = 3'd0; RegWriteW = 1'b0; LdTypeW = 3'd0;
        MDW = '0; AOW = '0; PCW = '0; HILO_resW = '0; CP0_DOutW = '0;
        WAW = '0; RA1 = '0; RA2 = '0;

        // 1. reset, then every address reads zero on both ports
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            settle();
            push($sformatf("reset_rd1_%0d", i), 32'h0);
            check(RD1);
            push($sformatf("reset_rd2_%0d", 31 - i), 32'h0);
            check(RD2);
        end

        // 2. ALU result write to $5
        RegWriteW = 1'b1; WAW = 5'd5; MemtoRegW = 3'd0; AOW = 32'h1234_5678;
        settle();
        push("alu_wdw", 32'h1234_5678); check(WDW);
        push("alu_wew", 32'h1);         check(32'(WEW));
        tick();
        RegWriteW = 1'b0; RA1 = 5'd5;
        settle();
        push("alu_rd1_r5", 32'h1234_5678); check(RD1);

        // write to $0 is discarded
        RegWriteW = 1'b1; WAW = 5'd0; AOW = 32'hAAAA_5555;
        settle();
        push("r0_wew", 32'h0); check(32'(WEW));
        tick();
        RegWriteW = 1'b0; RA1 = 5'd0;
        settle();
        push("r0_rd1", 32'h0); check(RD1);

        // 3. sub-word loads
        MemtoRegW = 3'd1; MDW = 32'h80FF_7F81;
        LdTypeW = 3'd2; AOW = 32'h0000_1000; settle();
        push("lb_b0", 32'hFFFF_FF81); check(WDW);
        LdTypeW = 3'd2; AOW = 32'h0000_1001; settle();
        push("lb_b1", 32'h0000_007F); check(WDW);
        LdTypeW = 3'd1; AOW = 32'h0000_1003; settle();
        push("lbu_b3", 32'h0000_0080); check(WDW);
        LdTypeW = 3'd4; AOW = 32'h0000_1002; settle();
        push("lh_h1", 32'hFFFF_80FF); check(WDW);
        LdTypeW = 3'd3; AOW = 32'h0000_1000; settle();
        push("lhu_h0", 32'h0000_7F81); check(WDW);
        LdTypeW = 3'd0; AOW = 32'h0000_1002; settle();
        push("lw", 32'h80FF_7F81); check(WDW);
        LdTypeW = 3'd6; settle();
        push("ld_type6_word", 32'h80FF_7F81); check(WDW);

        // loaded byte is written to $7
        LdTypeW = 3'd2; AOW = 32'h0000_1000; RegWriteW = 1'b1; WAW = 5'd7;
        tick();
        RegWriteW = 1'b0; RA2 = 5'd7; settle();
        push("lb_rd2_r7", 32'hFFFF_FF81); check(RD2);

        // 4. link writes, including 32-bit wrap
        MemtoRegW = 3'd2; PCW = 32'h0000_3010; RegWriteW = 1'b1; WAW = 5'd31;
        tick();
        PCW = 32'hFFFF_FFFC; WAW = 5'd30;
        settle();
        push("link_wrap_wdw", 32'h0000_0004); check(WDW);
        tick();
        RegWriteW = 1'b0; RA1 = 5'd31; RA2 = 5'd30; settle();
        push("link_r31", 32'h0000_3018); check(RD1);
        push("link_r30", 32'h0000_0004); check(RD2);

        // 5. same-cycle write and read of $9
        MemtoRegW = 3'd0; AOW = 32'hDEAD_BEEF; RegWriteW = 1'b1; WAW = 5'd9;
        RA1 = 5'd5; RA2 = 5'd9; settle();
`ifdef GRF_BYPASS_EN
        push("wbr_rd2_pre", 32'hDEAD_BEEF); check(RD2);
`else
        push("wbr_rd2_pre", 32'h0); check(RD2);
`endif
        push("wbr_rd1_other", 32'h1234_5678); check(RD1);
        tick();
        RegWriteW = 1'b0; settle();
        push("wbr_rd2_post", 32'hDEAD_BEEF); check(RD2);

        // HILO / CP0 / undefined selects
        HILO_resW = 32'h0BAD_F00D; CP0_DOutW = 32'hC0C0_0001;
        MemtoRegW = 3'd3; settle(); push("sel_hilo", 32'h0BAD_F00D); check(WDW);
        MemtoRegW = 3'd4; settle(); push("sel_cp0", 32'hC0C0_0001); check(WDW);
        MemtoRegW = 3'd5; settle(); push("sel_5", 32'h0); check(WDW);
        MemtoRegW = 3'd7; settle(); push("sel_7", 32'h0); check(WDW);

        // 6. preload $3, then reset together with a write to $3
        MemtoRegW = 3'd0; AOW = 32'h0000_0055; RegWriteW = 1'b1; WAW = 5'd3;
        tick();
        RegWriteW = 1'b0; RA1 = 5'd3; settle();
        push("pre_r3", 32'h0000_0055); check(RD1);
        reset = 1'b1; RegWriteW = 1'b1; WAW = 5'd3; AOW = 32'h7777_7777;
        settle();
        push("rst_wew_ungated", 32'h1); check(32'(WEW));
        push("rst_wdw_ungated", 32'h7777_7777); check(WDW);
        tick();
        reset = 1'b0; RegWriteW = 1'b0; RA1 = 5'd3; RA2 = 5'd31; settle();
        push("rst_r3", 32'h0); check(RD1);
        push("rst_r31", 32'h0); check(RD2);
        RA1 = 5'd5; RA2 = 5'd9; settle();
        push("rst_r5", 32'h0); check(RD1);
        push("rst_r9", 32'h0); check(RD2);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
